// File: rtl/sr_updown_counter.sv
// Parametrised up/down modulo counter with synchronous clear/load and a registered terminal-count pulse.
// Define COUNTER_SAT_EN to build the saturating variant (holds at the bounds instead of wrapping).
module sr_updown_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_next;
    logic             tc_next;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        count_next = count;
        tc_next    = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = (din > MAX) ? MAX : din;
        end else if (en && up) begin
            if (count >= MAX) begin
`ifdef COUNTER_SAT_EN
                count_next = MAX;
`else
                count_next = '0;
`endif
                tc_next    = 1'b1;
            end else begin
                count_next = count + ONE;
            end
        end else if (en) begin
            if (count == '0) begin
`ifdef COUNTER_SAT_EN
                count_next = '0;
`else
                count_next = MAX;
`endif
                tc_next    = 1'b1;
            end else begin
                count_next = count - ONE;
            end
        end
    end

    // NOTE: non-blocking assignments for all clocked state avoid simulation ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_sr_updown_counter.sv
// Self-checking bench for sr_updown_counter: an arithmetic model checked every cycle on two
// instances (WIDTH=4/MODULUS=10 and WIDTH=3/MODULUS=8) plus directed literal expectations.
module tb_sr_updown_counter;

    typedef struct {
        int c;
        bit t;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] din = 4'd0;
    logic [2:0] din_b;
    logic [3:0] count_a;
    logic [2:0] count_b;
    logic       tc_a, tc_b, zero_a, zero_b;

    int total  = 0;
    int passed = 0;
    int m_a = 0, m_b = 0;
    bit t_a = 1'b0, t_b = 1'b0;

    assign din_b = din[2:0];

    always #5 clk = ~clk;

    sr_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .din(din), .count(count_a), .tc(tc_a), .zero(zero_a)
    );

    sr_updown_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .din(din_b), .count(count_b), .tc(tc_b), .zero(zero_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Model: next state from plain modular arithmetic on integers.
    function automatic mstate_t next_state(input int m, input int c, input bit e, input bit u,
                                           input bit cl, input bit ld, input int d);
        mstate_t s;
        s.c = c;
        s.t = 1'b0;
        if (cl) s.c = 0;
        else if (ld) s.c = (d > m - 1) ? m - 1 : d;
        else if (e) begin
`ifdef COUNTER_SAT_EN
            if (u) begin
                s.t = (c == m - 1);
                s.c = s.t ? c : c + 1;
            end else begin
                s.t = (c == 0);
                s.c = s.t ? c : c - 1;
            end
`else
            s.c = u ? (c + 1) % m : (c + m - 1) % m;
            s.t = u ? (s.c == 0) : (s.c == m - 1);
`endif
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a <= 0; t_a <= 1'b0;
            m_b <= 0; t_b <= 1'b0;
        end else begin
            mstate_t sa, sb;
            sa = next_state(10, m_a, en, up, clr, load, int'(din));
            sb = next_state(8, m_b, en, up, clr, load, int'(din_b));
            m_a <= sa.c; t_a <= sa.t;
            m_b <= sb.c; t_b <= sb.t;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_a_count", int'(count_a), m_a);
        check("model_a_tc",    int'(tc_a),    int'(t_a));
        check("model_a_zero",  int'(zero_a),  int'(m_a == 0));
        check("model_b_count", int'(count_b), m_b);
        check("model_b_tc",    int'(tc_b),    int'(t_b));
        check("model_b_zero",  int'(zero_b),  int'(m_b == 0));
    end

    task automatic step(input bit e, input bit u, input bit cl, input bit ld, input logic [3:0] d);
        en = e; up = u; clr = cl; load = ld; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_a_count", int'(count_a), 0);
        check("rst_a_tc",    int'(tc_a),    0);
        check("rst_a_zero",  int'(zero_a),  1);
        @(negedge clk);
        rst = 1'b1;

`ifndef COUNTER_SAT_EN
        // Wrap up on MODULUS=10: 1..9 then 0, tc only on the wrap edge
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 0, 0, 4'd0);
            check("wrap_up_count", int'(count_a), (i == 10) ? 0 : i);
            check("wrap_up_tc",    int'(tc_a),    (i == 10) ? 1 : 0);
        end
        // Wrap down on MODULUS=8 from 0: 7 with tc, then 6 without
        step(0, 0, 1, 0, 4'd0);
        step(1, 0, 0, 0, 4'd0);
        check("wrap_dn_b_count", int'(count_b), 7);
        check("wrap_dn_b_tc",    int'(tc_b),    1);
        check("wrap_dn_a_count", int'(count_a), 9);
        step(1, 0, 0, 0, 4'd0);
        check("wrap_dn_b_count2", int'(count_b), 6);
        check("wrap_dn_b_tc2",    int'(tc_b),    0);
`else
        // Saturation on MODULUS=10: from 8, up x3 -> 9,9,9 tc 0,1,1; then down -> 8
        step(0, 0, 0, 1, 4'd8);
        step(1, 1, 0, 0, 4'd0);
        check("sat_count1", int'(count_a), 9);
        check("sat_tc1",    int'(tc_a),    0);
        step(1, 1, 0, 0, 4'd0);
        check("sat_count2", int'(count_a), 9);
        check("sat_tc2",    int'(tc_a),    1);
        step(1, 1, 0, 0, 4'd0);
        check("sat_count3", int'(count_a), 9);
        check("sat_tc3",    int'(tc_a),    1);
        step(1, 0, 0, 0, 4'd0);
        check("sat_down_count", int'(count_a), 8);
        check("sat_down_tc",    int'(tc_a),    0);
`endif

        // Priority and clamp
        step(1, 1, 1, 1, 4'd5);
        check("prio_clr", int'(count_a), 0);
        step(0, 1, 0, 1, 4'd13);
        check("clamp_a", int'(count_a), 9);
        check("clamp_b", int'(count_b), 5);
        step(1, 1, 0, 1, 4'd4);
        check("load_over_en", int'(count_a), 4);

        // Direction toggle and hold
        step(0, 0, 0, 1, 4'd3);
        step(1, 1, 0, 0, 4'd0);
        check("dir_up",   int'(count_a), 4);
        step(1, 0, 0, 0, 4'd0);
        check("dir_down", int'(count_a), 3);
        step(1, 1, 0, 0, 4'd0);
        check("dir_up2",  int'(count_a), 4);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 4'd0);
            check("hold_count", int'(count_a), 4);
            check("hold_tc",    int'(tc_a),    0);
        end

        // Deterministic mixed pattern, checked by the model each cycle
        for (int i = 0; i < 40; i++) begin
            step(bit'((i % 7) != 0), bit'((i / 5) % 2), bit'(i == 23), bit'((i % 11) == 5),
                 4'(i * 3));
        end

        // Asynchronous reset mid-count, no clock edge needed
        step(0, 1, 0, 1, 4'd5);
        check("pre_rst_count", int'(count_a), 5);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", int'(count_a), 0);
        check("async_rst_tc",    int'(tc_a),    0);
        check("async_rst_zero",  int'(zero_a),  1);
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 0, 0, 4'd0);
        check("post_rst_count", int'(count_a), 1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
